uart_fifo_peripheral: RTL and testbench
=======================================

Name: uart_fifo_peripheral

Overview:
Memory-mapped UART peripheral on the CPU data bus, a parametrised successor to the fixed single-byte UART path.
- Adds TX and RX FIFOs of configurable depth, a runtime baud divisor, sticky overrun and framing error flags, and a maskable level interrupt.
- Sits beside the LED/switch/digit peripheral; its `rdata` is muxed into the peripheral read path by address decode.

Parameters:
- `FIFO_DEPTH`, 16, entries per FIFO; power of 2, minimum 2.
- `DIV_DEFAULT`, 16'd433, baud divisor reset value. One bit period is `DIV+1` clocks.
- `BASE_ADDR`, 32'h4000_0020, base address of the 5-word register window.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `sel`  in  1  address decode hit for this block (`addr` within window)
- `rd`  in  1  read strobe, held for the whole bus cycle
- `wr`  in  1  write strobe, held for the whole bus cycle
- `addr`  in  32  byte address; `addr[4:2]` selects the register
- `wdata`  in  32  write data
- `rdata`  out  32  read data, combinational from `addr`/`rd`/`sel`; 0 when not selected
- `uart_rx`  in  1  serial input, asynchronous
- `uart_tx`  out  1  serial output, idle high
- `irqout`  out  1  level interrupt

Behaviour:
Clock and reset
- One clock (`clk`). Reset is synchronous and active-high (`reset`).
- Reset values: `uart_tx`=1, `irqout`=0, both FIFOs empty, CTRL=0x3, BAUD_DIV=`DIV_DEFAULT`, all flags 0, both FSMs IDLE.
- Reset mid-frame aborts the frame; `uart_tx`=1 from the cycle after the reset edge.

Register map (offset, access, meaning)
- 0x00 TXDATA, W: push `wdata[7:0]` into the TX FIFO. Write while full is ignored; nothing else changes.
- 0x04 RXDATA, R: `rdata={24'b0,head}`. The pop occurs on the clock edge ending the read. Reading while empty returns 0 and does not pop.
- 0x08 STATUS, R: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_busy, bit5 rx_overrun, bit6 frame_err, bits[15:8] rx_count.
- 0x08 STATUS, W: writing 1 to bit5 or bit6 clears that flag. A set in the same cycle wins over the clear.
- 0x0C CTRL, R/W: bit0 tx_en, bit1 rx_en, bit2 irq_rx_en, bit3 irq_tx_en.
- 0x10 BAUD_DIV, R/W: `[15:0]`. Latched by each FSM at frame start; a change never alters a frame in flight.
- Other offsets read 0; writes to them are ignored.

FIFOs
- Push and pop in the same cycle are both performed and the count is unchanged. This also holds when the FIFO is full.
- RX push while full and not popping: byte dropped, rx_overrun set.

TX FSM: IDLE → START → DATA → STOP → IDLE
- IDLE → START when tx_en=1 and TX FIFO non-empty. The byte is popped on that edge; `uart_tx`=0 from the next cycle.
- Each state bit lasts `DIV+1` clocks. DATA sends 8 bits, LSB first. STOP drives 1 for one bit period.
- STOP returns to IDLE, or goes directly to START if the FIFO is non-empty. There is no idle gap between frames.
- Clearing tx_en mid-frame finishes the current frame, then holds IDLE.
- tx_busy = state≠IDLE.

RX FSM: IDLE → START → DATA → STOP → IDLE
- `uart_rx` passes through a 2-flop synchroniser before use.
- IDLE → START on a synchronised 1→0 edge while rx_en=1.
- START re-samples at `DIV/2` clocks. If the line is 1, it is a glitch: return to IDLE.
- DATA samples 8 bits at mid-bit, each `DIV+1` clocks apart, LSB first.
- STOP samples at mid-bit:
  - 1: push the byte.
  - 0: set frame_err and discard the byte.
- IDLE is re-entered right after the stop-bit sample.

Interrupt
- `irqout` = (irq_rx_en & ~rx_empty) | (irq_tx_en & tx_empty & ~tx_busy), registered one cycle.

Decomposition:
- Package `uart_periph_pkg`:
  - register offset constants,
  - STATUS and CTRL bit indices,
  - `tx_state_t` and `rx_state_t` enums,
  - CTRL reset constant.
- Sub-module `sync_fifo`, parametrised on WIDTH/DEPTH, instantiated twice:
  - outputs: full, empty, count;
  - first-word-fall-through head output.
- Both FSMs and the register file live in the top.

Test Plan:
1. DIV=3; write TXDATA=0x55 at edge N → `uart_tx` low from edge N+1 for 4 clocks, then bits 1,0,1,0,1,0,1,0 for 4 clocks each, then high. tx_busy falls 40 clocks after N+1.
2. DIV=3; write 0x01,0x02,0x03 back-to-back → three contiguous 40-clock frames with no idle between them. tx_empty=1 after the first pop of 0x03.
3. DIV=3; drive RX frame 0xA3 on `uart_rx` → rx_count=1 and RXDATA reads 0x000000A3. After the read, rx_empty=1. With irq_rx_en=1, `irqout` rises after the push and falls after the pop.
4. `FIFO_DEPTH`=4; receive 5 bytes without reading → rx_full=1, rx_overrun=1, and the first 4 bytes read back intact. Write STATUS bit5=1 → rx_overrun=0.
5. RX frame with stop bit 0 → frame_err=1 and rx_count unchanged. A 1-clock low glitch on `uart_rx` → no byte received and no flags set.
6. Assert `reset` mid-TX-frame → `uart_tx`=1 next cycle, FIFOs empty, CTRL=0x3, BAUD_DIV=`DIV_DEFAULT`. Reading an empty RXDATA returns 0 and rx_count stays 0.

Source files
------------

// File: rtl/uart_periph_pkg.sv
// Shared definitions for the memory-mapped UART: register indices, bit positions, FSM states.
// No logic; imported by the peripheral top.
// No backpressure; constants only.
package uart_periph_pkg;

  localparam logic [2:0] REG_TXDATA   = 3'd0;
  localparam logic [2:0] REG_RXDATA   = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_CTRL     = 3'd3;
  localparam logic [2:0] REG_BAUD_DIV = 3'd4;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_TX_BUSY    = 4;
  localparam int ST_RX_OVERRUN = 5;
  localparam int ST_FRAME_ERR  = 6;

  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_IRQ_RX_EN = 2;
  localparam int CTRL_IRQ_TX_EN = 3;

  localparam logic [3:0] CTRL_RESET = 4'h3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head_dat shows the oldest entry combinationally.
// Latency: a pushed word is visible at head_dat the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  // When full, a simultaneous pop frees the slot being written, so both proceed.
  assign do_push  = push & (~full | pop);
  assign do_pop   = pop & ~empty;
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uart_fifo_peripheral.sv
// Memory-mapped UART with TX/RX FIFOs, runtime baud divisor, sticky error flags and level irq.
// Latency: TX line drops the cycle after the FIFO pop; RX byte lands one cycle after stop sample.
// Backpressure: TX writes while full are ignored; RX bytes arriving while full are dropped (overrun).
module uart_fifo_peripheral #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DIV_DEFAULT = 16'd433,
  parameter logic [31:0] BASE_ADDR   = 32'h4000_0020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irqout
);

  import uart_periph_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    ctrl;
  logic [15:0]   baud_div;
  logic          rx_overrun, frame_err;
  logic          hit, wr_hit, rd_hit;
  logic [2:0]    reg_idx;
  logic          tx_push, rx_pop, st_wr;
  logic [31:0]   status_word;
  logic          unused_bits;

  logic          tx_full, tx_empty, tx_pop, tx_busy, tx_go, tx_tick;
  logic [7:0]    tx_head;
  logic [CW-1:0] tx_count_unused;
  tx_state_t     tx_state, tx_state_n;
  logic [15:0]   tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic [2:0]    tx_bit, tx_bit_n;

  logic          rx_full, rx_empty, rx_push, rx_ferr;
  logic [7:0]    rx_head;
  logic [CW-1:0] rx_count;
  logic          rx_s1, rx_s2, rx_prev;
  rx_state_t     rx_state, rx_state_n;
  logic [15:0]   rx_cnt, rx_cnt_n, rx_div, rx_div_n, rx_half;
  logic [7:0]    rx_shift, rx_shift_n;
  logic [2:0]    rx_bit, rx_bit_n;

  assign hit     = sel & (addr[31:5] == BASE_ADDR[31:5]);
  assign wr_hit  = hit & wr;
  assign rd_hit  = hit & rd;
  assign reg_idx = addr[4:2];
  assign tx_push = wr_hit & (reg_idx == REG_TXDATA);
  assign rx_pop  = rd_hit & (reg_idx == REG_RXDATA);
  assign st_wr   = wr_hit & (reg_idx == REG_STATUS);
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .push_dat(wdata[7:0]), .pop(tx_pop),
    .head_dat(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count_unused)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_dat(rx_shift_n), .pop(rx_pop),
    .head_dat(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_comb begin
    status_word                = '0;
    status_word[ST_TX_FULL]    = tx_full;
    status_word[ST_TX_EMPTY]   = tx_empty;
    status_word[ST_RX_FULL]    = rx_full;
    status_word[ST_RX_EMPTY]   = rx_empty;
    status_word[ST_TX_BUSY]    = tx_busy;
    status_word[ST_RX_OVERRUN] = rx_overrun;
    status_word[ST_FRAME_ERR]  = frame_err;
    status_word[15:8]          = 8'(rx_count);
  end

  always_comb begin
    rdata = '0;
    if (rd_hit) begin
      case (reg_idx)
        REG_RXDATA:   rdata = rx_empty ? 32'b0 : {24'b0, rx_head};
        REG_STATUS:   rdata = status_word;
        REG_CTRL:     rdata = {28'b0, ctrl};
        REG_BAUD_DIV: rdata = {16'b0, baud_div};
        default:      rdata = '0;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl       <= CTRL_RESET;
      baud_div   <= DIV_DEFAULT;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      irqout     <= 1'b0;
    end else begin
      if (wr_hit && reg_idx == REG_CTRL)     ctrl     <= wdata[3:0];
      if (wr_hit && reg_idx == REG_BAUD_DIV) baud_div <= wdata[15:0];
      rx_overrun <= (rx_push & rx_full & ~rx_pop) |
                    (rx_overrun & ~(st_wr & wdata[ST_RX_OVERRUN]));
      frame_err  <= rx_ferr | (frame_err & ~(st_wr & wdata[ST_FRAME_ERR]));
      irqout     <= (ctrl[CTRL_IRQ_RX_EN] & ~rx_empty) |
                    (ctrl[CTRL_IRQ_TX_EN] & tx_empty & ~tx_busy);
    end
  end

  assign tx_busy = (tx_state != TX_IDLE);
  assign tx_go   = ctrl[CTRL_TX_EN] & ~tx_empty;
  assign tx_tick = (tx_cnt == tx_div);
  assign uart_tx = (tx_state == TX_START) ? 1'b0 :
                   (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_div_n   = tx_div;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    tx_pop     = 1'b0;
    if (tx_state != TX_IDLE) tx_cnt_n = tx_tick ? 16'd0 : tx_cnt + 16'd1;
    case (tx_state)
      TX_IDLE: if (tx_go) begin
        tx_state_n = TX_START;
        tx_pop     = 1'b1;
        tx_shift_n = tx_head;
        tx_div_n   = baud_div;
        tx_cnt_n   = 16'd0;
      end
      TX_START: if (tx_tick) begin
        tx_state_n = TX_DATA;
        tx_bit_n   = 3'd0;
      end
      TX_DATA: if (tx_tick) begin
        if (tx_bit == 3'd7) begin
          tx_state_n = TX_STOP;
        end else begin
          tx_bit_n   = tx_bit + 3'd1;
          tx_shift_n = {1'b0, tx_shift[7:1]};
        end
      end
      TX_STOP: if (tx_tick) begin
        // Chain straight into the next frame so back-to-back bytes have no idle gap.
        if (tx_go) begin
          tx_state_n = TX_START;
          tx_pop     = 1'b1;
          tx_shift_n = tx_head;
          tx_div_n   = baud_div;
        end else begin
          tx_state_n = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_div   <= tx_div_n;
      tx_shift <= tx_shift_n;
      tx_bit   <= tx_bit_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_half = {1'b0, rx_div[15:1]};

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_div_n   = rx_div;
    rx_shift_n = rx_shift;
    rx_bit_n   = rx_bit;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state)
      RX_IDLE: if (ctrl[CTRL_RX_EN] && rx_prev && !rx_s2) begin
        rx_state_n = RX_START;
        rx_cnt_n   = 16'd0;
        rx_div_n   = baud_div;
      end
      RX_START: if (rx_cnt == rx_half) begin
        // Line back high at mid start bit means a glitch, not a frame.
        rx_cnt_n = 16'd0;
        if (rx_s2) begin
          rx_state_n = RX_IDLE;
        end else begin
          rx_state_n = RX_DATA;
          rx_bit_n   = 3'd0;
        end
      end else begin
        rx_cnt_n = rx_cnt + 16'd1;
      end
      RX_DATA: if (rx_cnt == rx_div) begin
        rx_cnt_n   = 16'd0;
        rx_shift_n = {rx_s2, rx_shift[7:1]};
        if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        else                rx_bit_n   = rx_bit + 3'd1;
      end else begin
        rx_cnt_n = rx_cnt + 16'd1;
      end
      RX_STOP: if (rx_cnt == rx_div) begin
        rx_cnt_n   = 16'd0;
        rx_state_n = RX_IDLE;
        rx_push    = rx_s2;
        rx_ferr    = ~rx_s2;
      end else begin
        rx_cnt_n = rx_cnt + 16'd1;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_shift <= rx_shift_n;
      rx_bit   <= rx_bit_n;
    end
  end

endmodule

// File: tb/tb_uart_fifo_peripheral.sv
// Bench for uart_fifo_peripheral: directed bus/serial stimulus, expected values queued,
// and separate monitors for bus reads and the serial TX line that pop and compare.
module tb_uart_fifo_peripheral;

  localparam logic [31:0] BASE   = 32'h4000_0020;
  localparam logic [4:0]  O_TX   = 5'h00;
  localparam logic [4:0]  O_RX   = 5'h04;
  localparam logic [4:0]  O_ST   = 5'h08;
  localparam logic [4:0]  O_CTRL = 5'h0C;
  localparam logic [4:0]  O_BAUD = 5'h10;

  logic        clk, reset, sel, rd, wr, uart_rx, uart_tx, irqout;
  logic [31:0] addr, wdata, rdata;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [31:0] rd_exp_q [$];
  string       rd_name_q [$];
  logic [7:0]  tx_exp_q [$];
  int          tx_start_q [$];

  uart_fifo_peripheral #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .sel(sel), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irqout(irqout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic bus_write(input logic [4:0] off, input logic [31:0] d);
    sel = 1'b1; wr = 1'b1; addr = BASE + {27'b0, off}; wdata = d;
    tick();
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] off, input logic [31:0] exp, input string name);
    rd_exp_q.push_back(exp);
    rd_name_q.push_back(name);
    sel = 1'b1; rd = 1'b1; addr = BASE + {27'b0, off};
    tick();
    sel = 1'b0; rd = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (4) tick();
    end
    uart_rx = 1'b1;
  endtask

  // Bus read monitor: rdata sampled mid-cycle while a read is presented.
  always @(negedge clk) begin
    logic [31:0] e;
    string       n;
    if (sel && rd) begin
      if (rd_exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: got 0x%08h with no expected value queued", rdata);
      end else begin
        e = rd_exp_q.pop_front();
        n = rd_name_q.pop_front();
        check(n, rdata, e);
      end
    end
  end

  // Serial TX monitor: 40 samples per frame at DIV=3, one per clock.
  initial begin : tx_mon
    logic        prev, ok, abort;
    logic [39:0] smp;
    logic [7:0]  got;
    int          st;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset && prev === 1'b1 && uart_tx === 1'b0) begin
        st = cyc; smp = '0; abort = 1'b0;
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (reset) abort = 1'b1;
          smp[i] = uart_tx;
        end
        if (!abort) begin
          ok = 1'b1;
          for (int b = 0; b < 10; b++)
            for (int j = 1; j < 4; j++)
              if (smp[b*4+j] !== smp[b*4]) ok = 1'b0;
          if (smp[36] !== 1'b1) ok = 1'b0;
          for (int b = 0; b < 8; b++) got[b] = smp[(b+1)*4+2];
          if (tx_exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL tx_unexpected: frame 0x%02h at cycle %0d, none expected", got, st);
          end else begin
            check("tx_byte", {24'b0, got}, {24'b0, tx_exp_q.pop_front()});
            check("tx_start_cycle", st, tx_start_q.pop_front());
            check("tx_frame_shape", {31'b0, ok}, 32'd1);
          end
        end
      end
      prev = uart_tx;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d tests run so far", tests);
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int k, w;
    clk = 1'b0; reset = 1'b1; sel = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = '0; wdata = '0; uart_rx = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_irqout", {31'b0, irqout}, 32'd0);
    bus_read(O_ST, 32'h0000_000A, "rst_status");
    bus_read(O_CTRL, 32'h0000_0003, "rst_ctrl");
    bus_read(O_BAUD, 32'd433, "rst_baud");
    bus_read(5'h14, 32'h0, "unmapped_rd");

    // 1: single frame timing with DIV=3
    bus_write(O_BAUD, 32'd3);
    bus_read(O_BAUD, 32'd3, "baud_rdback");
    tx_exp_q.push_back(8'h55);
    tx_start_q.push_back(cyc + 2);
    bus_write(O_TX, 32'h55);
    w = cyc;
    wait_until(w + 40);
    bus_read(O_ST, 32'h0000_001A, "t1_busy_last_cycle");
    bus_read(O_ST, 32'h0000_000A, "t1_busy_fell");
    repeat (4) tick();

    // 2: three back-to-back frames, no idle gap
    k = cyc;
    tx_exp_q.push_back(8'h01); tx_start_q.push_back(k + 2);
    tx_exp_q.push_back(8'h02); tx_start_q.push_back(k + 42);
    tx_exp_q.push_back(8'h03); tx_start_q.push_back(k + 82);
    bus_write(O_TX, 32'h01);
    bus_write(O_TX, 32'h02);
    bus_write(O_TX, 32'h03);
    wait_until(k + 81);
    bus_read(O_ST, 32'h0000_0018, "t2_before_last_pop");
    bus_read(O_ST, 32'h0000_001A, "t2_after_last_pop");
    wait_until(k + 130);

    // 3: receive 0xA3 with rx interrupt enabled
    bus_write(O_CTRL, 32'h7);
    send_rx(8'hA3, 1'b1);
    repeat (4) tick();
    check("t3_irq_after_push", {31'b0, irqout}, 32'd1);
    bus_read(O_ST, 32'h0000_0102, "t3_status_count1");
    bus_read(O_RX, 32'h0000_00A3, "t3_rxdata");
    check("t3_irq_registered", {31'b0, irqout}, 32'd1);
    tick();
    check("t3_irq_after_pop", {31'b0, irqout}, 32'd0);
    bus_read(O_ST, 32'h0000_000A, "t3_status_empty");
    bus_write(O_CTRL, 32'h3);

    // 4: overrun with a 4-deep FIFO
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    send_rx(8'h33, 1'b1);
    send_rx(8'h44, 1'b1);
    send_rx(8'h55, 1'b1);
    repeat (4) tick();
    bus_read(O_ST, 32'h0000_0426, "t4_full_overrun");
    bus_read(O_RX, 32'h11, "t4_rx0");
    bus_read(O_RX, 32'h22, "t4_rx1");
    bus_read(O_RX, 32'h33, "t4_rx2");
    bus_read(O_RX, 32'h44, "t4_rx3");
    bus_read(O_ST, 32'h0000_002A, "t4_drained");
    bus_write(O_ST, 32'h20);
    bus_read(O_ST, 32'h0000_000A, "t4_overrun_cleared");

    // 5: framing error, then a one-clock glitch
    send_rx(8'h5A, 1'b0);
    repeat (4) tick();
    bus_read(O_ST, 32'h0000_004A, "t5_frame_err");
    bus_write(O_ST, 32'h40);
    bus_read(O_ST, 32'h0000_000A, "t5_ferr_cleared");
    uart_rx = 1'b0;
    tick();
    uart_rx = 1'b1;
    repeat (20) tick();
    bus_read(O_ST, 32'h0000_000A, "t5_glitch_ignored");
    bus_read(O_RX, 32'h0, "t5_rx_empty_read");

    // 6: reset in the middle of a TX frame with a byte still queued
    bus_write(O_TX, 32'hC3);
    bus_write(O_TX, 32'h3C);
    tick();
    check("t6_line_low_before_reset", {31'b0, uart_tx}, 32'd0);
    reset = 1'b1;
    tick();
    check("t6_uart_tx_after_reset", {31'b0, uart_tx}, 32'd1);
    reset = 1'b0;
    check("t6_irqout_after_reset", {31'b0, irqout}, 32'd0);
    bus_read(O_ST, 32'h0000_000A, "t6_status");
    bus_read(O_CTRL, 32'h3, "t6_ctrl");
    bus_read(O_BAUD, 32'd433, "t6_baud");
    bus_read(O_RX, 32'h0, "t6_rx_empty_read");
    bus_read(O_ST, 32'h0000_000A, "t6_rx_count_zero");
    repeat (50) tick();

    check("rd_queue_drained", rd_exp_q.size(), 32'd0);
    check("tx_queue_drained", tx_exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
